// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared core constants for the pipeline-stage modules
package reg_file_pkg;
  localparam int REG_NUM_BITWIDTH_DEF = 5;
  localparam int WORD_BITWIDTH_DEF = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: decode read ports, write-back port, load issue and hazard status
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEF,
  parameter int WORD_BITWIDTH = WORD_BITWIDTH_DEF
);
  logic                             wb_regWrite;
  logic [REG_NUM_BITWIDTH-1:0]      wb_regToWrite;
  logic [WORD_BITWIDTH-1:0]         wb_regWriteData;
  logic [REG_NUM_BITWIDTH-1:0]      rs1, rs2;
  logic [WORD_BITWIDTH-1:0]         rd1, rd2;
  logic                             ld_issue;
  logic [REG_NUM_BITWIDTH-1:0]      ld_rd;
  logic                             hazard1, hazard2;
  logic [2**REG_NUM_BITWIDTH-1:0]   busy_vec;
  modport master (
    output wb_regWrite, wb_regToWrite, wb_regWriteData, rs1, rs2, ld_issue, ld_rd,
    input  rd1, rd2, hazard1, hazard2, busy_vec
  );
  modport slave (
    input  wb_regWrite, wb_regToWrite, wb_regWriteData, rs1, rs2, ld_issue, ld_rd,
    output rd1, rd2, hazard1, hazard2, busy_vec
  );
endinterface

// File: rtl/reg_file_load_scoreboard.sv
// load_scoreboard: pending-load busy bits; a same-index set beats a clear
module load_scoreboard #(
  parameter int RW = 5,
  parameter int N = 2**RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  output logic [N-1:0]  busy_vec
);
  logic [N-1:0] set_mask, clr_mask;
  assign set_mask = set_en ? N'(1) << set_idx : '0;
  assign clr_mask = clr_en ? N'(1) << clr_idx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_vec <= '0;
    else busy_vec <= (busy_vec & ~clr_mask) | set_mask;
endmodule

// File: rtl/reg_file.sv
// reg_file: register file with write-back bypass and load-use hazard scoreboard
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEF,
  parameter int WORD_BITWIDTH = WORD_BITWIDTH_DEF
) (
  input logic       clk,
  input logic       rst_n,
  reg_file_if.slave bus
);
  localparam int NREG = 2**REG_NUM_BITWIDTH;
  localparam logic [REG_NUM_BITWIDTH-1:0] ZERO = REG_NUM_BITWIDTH'(ZERO_REG);
  logic [WORD_BITWIDTH-1:0] regs [NREG];
  logic wb_live, ld_live, byp1, byp2;
  // gating with rst_n keeps reads at zero while reset is held, even with a write presented
  assign wb_live = rst_n && bus.wb_regWrite && bus.wb_regToWrite != ZERO;
  assign ld_live = bus.ld_issue && bus.ld_rd != ZERO;
  assign byp1 = wb_live && bus.wb_regToWrite == bus.rs1;
  assign byp2 = wb_live && bus.wb_regToWrite == bus.rs2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else if (wb_live) regs[bus.wb_regToWrite] <= bus.wb_regWriteData;
  assign bus.rd1 = bus.rs1 == ZERO ? '0 : byp1 ? bus.wb_regWriteData : regs[bus.rs1];
  assign bus.rd2 = bus.rs2 == ZERO ? '0 : byp2 ? bus.wb_regWriteData : regs[bus.rs2];
  assign bus.hazard1 = bus.rs1 != ZERO && bus.busy_vec[bus.rs1] && !byp1;
  assign bus.hazard2 = bus.rs2 != ZERO && bus.busy_vec[bus.rs2] && !byp2;
  load_scoreboard #(.RW(REG_NUM_BITWIDTH), .N(NREG)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (ld_live),
    .set_idx  (bus.ld_rd),
    .clr_en   (wb_live),
    .clr_idx  (bus.wb_regToWrite),
    .busy_vec (bus.busy_vec)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scenarios plus random traffic against an array/bitset reference model
module tb_reg_file;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [32];
  logic [31:0] mbusy;
  reg_file_if bus ();
  reg_file dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(logic we, int wa, logic [31:0] wd, logic ld, int lr, int r1, int r2);
    bus.wb_regWrite = we;
    bus.wb_regToWrite = 5'(wa);
    bus.wb_regWriteData = wd;
    bus.ld_issue = ld;
    bus.ld_rd = 5'(lr);
    bus.rs1 = 5'(r1);
    bus.rs2 = 5'(r2);
  endtask

  function automatic logic wb_hits(logic [4:0] rs);
    return rst_n && bus.wb_regWrite && bus.wb_regToWrite != 0 && bus.wb_regToWrite == rs;
  endfunction

  function automatic logic [31:0] exp_rd(logic [4:0] rs);
    if (rs == 0) return 0;
    return wb_hits(rs) ? bus.wb_regWriteData : mem[rs];
  endfunction

  function automatic logic exp_hz(logic [4:0] rs);
    return rs != 0 && mbusy[rs] && !wb_hits(rs);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 0;
    mbusy = 0;
  endtask

  // compare every output to the model, take one edge, then advance the model
  task automatic tick();
    #2;
    check("rd1", bus.rd1, exp_rd(bus.rs1));
    check("rd2", bus.rd2, exp_rd(bus.rs2));
    check("hazard1", bus.hazard1, exp_hz(bus.rs1));
    check("hazard2", bus.hazard2, exp_hz(bus.rs2));
    check("busy_vec", bus.busy_vec, mbusy);
    @(posedge clk);
    if (rst_n) begin
      if (bus.wb_regWrite && bus.wb_regToWrite != 0) begin
        mem[bus.wb_regToWrite] = bus.wb_regWriteData;
        mbusy[bus.wb_regToWrite] = 1'b0;
      end
      if (bus.ld_issue && bus.ld_rd != 0) mbusy[bus.ld_rd] = 1'b1;
    end
    #1;
  endtask

  function automatic int pick();
    return ($urandom % 4 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    model_reset();
    drive(1, 5, 32'h1234, 1, 5, 5, 5);
    #1;
    check("reset_rd1", bus.rd1, 0);
    check("reset_hazard1", bus.hazard1, 0);
    check("reset_busy", bus.busy_vec, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 5, 0);
    @(posedge clk);
    #1;
    check("reset_discard_x5", bus.rd1, 0);
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0);
    #2;
    check("x5_rd1", bus.rd1, 32'hDEADBEEF);
    check("x0_rd2", bus.rd2, 0);
    tick();
    drive(1, 7, 32'h12345678, 0, 0, 7, 0);
    #2;
    check("bypass_rd1", bus.rd1, 32'h12345678);
    check("bypass_hazard1", bus.hazard1, 0);
    tick();
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("x0_rd1", bus.rd1, 0);
    check("x0_busy", bus.busy_vec, 0);
    tick();
    drive(0, 0, 0, 1, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3);
    #2;
    check("ld3_hazard2", bus.hazard2, 1);
    tick();
    drive(1, 3, 32'hA5, 0, 0, 0, 3);
    #2;
    check("wb3_hazard2", bus.hazard2, 0);
    check("wb3_rd2", bus.rd2, 32'hA5);
    tick();
    check("wb3_busy3", bus.busy_vec[3], 0);
    drive(1, 4, 32'h11, 1, 4, 0, 0);
    tick();
    check("setwin_busy4", bus.busy_vec[4], 1);
    drive(0, 0, 0, 0, 0, 4, 0);
    #2;
    check("setwin_rd1", bus.rd1, 32'h11);
    check("setwin_hazard1", bus.hazard1, 1);
    tick();
    drive(1, 6, 32'h66, 1, 2, 0, 0);
    tick();
    check("diff_busy2", bus.busy_vec[2], 1);
    check("diff_busy6", bus.busy_vec[6], 0);
    drive(1, 9, 32'h55, 1, 9, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 9, 0);
    #2;
    check("pre_rst_rd1", bus.rd1, 32'h55);
    check("pre_rst_busy9", bus.busy_vec[9], 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("async_rst_rd1", bus.rd1, 0);
    check("async_rst_busy", bus.busy_vec, 0);
    model_reset();
    drive(1, 9, 32'h77, 1, 9, 9, 9);
    #1;
    check("rst_wb_rd1", bus.rd1, 0);
    check("rst_hazard1", bus.hazard1, 0);
    @(posedge clk);
    #1;
    check("rst_discard_busy", bus.busy_vec, 0);
    check("rst_discard_rd2", bus.rd2, 0);
    @(negedge clk);
    rst_n = 1;
    drive(0, 0, 0, 0, 0, 9, 0);
    @(posedge clk);
    #1;
    for (int n = 0; n < 400; n++) begin
      drive($urandom % 2, pick(), $urandom, $urandom % 3 == 0, pick(), pick(), pick());
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter REG_NUM_BITWIDTH, default 5, SHALL give the register index width (2**REG_NUM_BITWIDTH registers).
REQ-002 Parameter WORD_BITWIDTH, default 32, SHALL give the register data width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wb_regWrite  input  1  write-back enable from the MEM/WB stage.
REQ-006 wb_regToWrite  input  REG_NUM_BITWIDTH  write-back destination index.
REQ-007 wb_regWriteData  input  WORD_BITWIDTH  write-back data.
REQ-008 rs1, rs2  input  REG_NUM_BITWIDTH each  read-port indices from decode.
REQ-009 rd1, rd2  output  WORD_BITWIDTH each  read data.
REQ-010 ld_issue  input  1  a load is issued this cycle with destination ld_rd.
REQ-011 ld_rd  input  REG_NUM_BITWIDTH  destination of the issued load.
REQ-012 hazard1, hazard2  output  1 each  the rs1/rs2 operand is pending a load and not yet available.
REQ-013 busy_vec  output  2**REG_NUM_BITWIDTH  current scoreboard contents, bit i = register i pending.

Function
REQ-014 Register 0 SHALL read as 0 always; writes and ld_issue targeting index 0 SHALL be ignored.
REQ-015 When wb_regWrite=1 and wb_regToWrite!=0, the register SHALL take wb_regWriteData at the next rising edge.
REQ-016 rd1/rd2 SHALL be combinational from rs1/rs2 with zero cycles of latency.
REQ-017 Bypass: if wb_regWrite=1, wb_regToWrite!=0 and wb_regToWrite equals rsN in the same cycle, rdN SHALL equal wb_regWriteData, not the stored value.
REQ-018 Scoreboard: ld_issue=1 with ld_rd!=0 SHALL set busy[ld_rd] at the next edge.
REQ-019 wb_regWrite=1 with wb_regToWrite!=0 SHALL clear busy[wb_regToWrite] at the next edge.
REQ-020 Set and clear of the same index in the same cycle: set SHALL win (busy stays 1).
REQ-021 Set and clear of different indices in the same cycle SHALL both take effect.
REQ-022 hazardN SHALL equal busy[rsN] AND NOT (same-cycle bypass hit on rsN); hazardN SHALL be 0 for rsN=0.
REQ-023 Issuing a load to an already-busy index SHALL leave it busy, with no error or count; a single write-back SHALL clear it.
REQ-024 Write-back to a non-busy index SHALL update data only; busy stays 0.

Reset
REQ-025 rst_n=0 SHALL immediately and asynchronously clear all registers to 0 and all busy bits to 0, including mid-operation; consequently rd1=rd2=0, hazard1=hazard2=0 and busy_vec=0.
REQ-026 Writes and issues presented during reset SHALL be discarded; normal operation SHALL resume at the first rising edge after rst_n returns to 1.

Structure
REQ-027 Defaults for REG_NUM_BITWIDTH/WORD_BITWIDTH and the zero-register index constant SHALL live in the shared core package used by the pipeline-stage modules.
REQ-028 The scoreboard SHALL be a separate sub-module named load_scoreboard (set/clear ports, busy_vec out); the storage array and bypass logic SHALL remain in reg_file.

Verification
REQ-029 Reset, then write x5=0xDEADBEEF; next cycle with rs1=5 -> rd1=0xDEADBEEF; rs2=0 -> rd2=0.
REQ-030 Same cycle: wb write x7=0x12345678 and rs1=7 -> rd1=0x12345678 combinationally; hazard1=0.
REQ-031 Write x0=0xFFFFFFFF, ld_issue ld_rd=0 -> rd with rs1=0 stays 0; busy_vec=0.
REQ-032 ld_issue ld_rd=3; next cycle rs2=3 -> hazard2=1; wb write x3=0xA5 in the following cycle -> hazard2=0 and rd2=0xA5 in that cycle; busy_vec[3]=0 after the edge.
REQ-033 ld_issue ld_rd=4 and wb write x4=0x11 in the same cycle -> after the edge busy_vec[4]=1 and x4 reads 0x11.
REQ-034 With x9=0x55 and busy_vec[9]=1, assert rst_n=0 between edges -> rd (rs1=9)=0 and busy_vec=0 immediately, without waiting for a clock edge.
